// File: rtl/prog_loader.sv
// prog_loader: boot-stage loader that writes a byte-stream program image
// (addr/len header, data, checksum) into memory and then releases the CPU.
//
// Ports:
//   clk, reset (async, active-low)
//   start                     one-cycle pulse; starts a load from IDLE/DONE/ERROR
//   in_data/in_valid/in_ready byte stream, transfer on valid && ready
//   mem_addr/mem_data/mem_wr  memory write bus, driven while bus_own=1
//   bus_own                   1 = loader owns the memory bus
//   cpu_reset                 active-low CPU reset, high only after a good load
//   busy, err                 load in progress / checksum failure
module prog_loader #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr,
  output logic              bus_own,
  output logic              cpu_reset,
  output logic              busy,
  output logic              err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_AH,
    S_AL,
    S_LH,
    S_LL,
    S_DATA,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] sum_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              mem_wr_q;
  logic              in_ready_q;
  logic              bus_own_q;
  logic              cpu_reset_q;
  logic              busy_q;
  logic              err_q;

  logic acc;
  logic launch;
  logic [ADDR_W-1:0] len_full;

  // in_ready_q mirrors "state_q is an accepting state", so it doubles
  // as the handshake qualifier.
  assign acc      = in_valid && in_ready_q;
  assign launch   = start && (state_q == S_IDLE ||
                              state_q == S_DONE ||
                              state_q == S_ERR);
  assign len_full = {cnt_q[ADDR_W-1:8], in_data};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR:
        if (start) state_d = S_AH;
      S_AH:
        if (acc) state_d = S_AL;
      S_AL:
        if (acc) state_d = S_LH;
      S_LH:
        if (acc) state_d = S_LL;
      S_LL:
        if (acc) begin
          if (len_full == '0) state_d = S_CSUM;
          else                state_d = S_DATA;
        end
      S_DATA:
        if (acc) state_d = S_SETUP;
      S_SETUP:
        state_d = S_WRITE;
      S_WRITE:
        state_d = S_HOLD;
      S_HOLD:
        if (cnt_q == ADDR_W'(1)) state_d = S_CSUM;
        else                     state_d = S_DATA;
      S_CSUM:
        if (acc) begin
          if (in_data == sum_q) state_d = S_DONE;
          else                  state_d = S_ERR;
        end
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_wr_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      bus_own_q   <= 1'b1;
      cpu_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;

      // Outputs decoded from next state so they are all flop outputs.
      in_ready_q  <= (state_d == S_AH)   || (state_d == S_AL) ||
                     (state_d == S_LH)   || (state_d == S_LL) ||
                     (state_d == S_DATA) || (state_d == S_CSUM);
      mem_wr_q    <= (state_d == S_WRITE);
      busy_q      <= !((state_d == S_IDLE) ||
                       (state_d == S_DONE) ||
                       (state_d == S_ERR));
      err_q       <= (state_d == S_ERR);
      cpu_reset_q <= (state_d == S_DONE);
      bus_own_q   <= (state_d != S_DONE);

      if (launch) sum_q <= '0;

      unique case (1'b1)
        (state_q == S_AH) && acc:
          ptr_q[ADDR_W-1:8] <= in_data[ADDR_W-9:0];
        (state_q == S_AL) && acc:
          ptr_q[7:0] <= in_data;
        (state_q == S_LH) && acc:
          cnt_q[ADDR_W-1:8] <= in_data[ADDR_W-9:0];
        (state_q == S_LL) && acc:
          cnt_q[7:0] <= in_data;
        (state_q == S_DATA) && acc: begin
          mem_data_q <= in_data;
          mem_addr_q <= ptr_q;
          sum_q      <= sum_q + in_data;
        end
        (state_q == S_HOLD): begin
          ptr_q <= ptr_q + 1'b1;
          cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase

      // CPU takes the bus in DONE; the loader side must read as zero.
      if (state_d == S_DONE) begin
        mem_addr_q <= '0;
        mem_data_q <= '0;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_wr    = mem_wr_q;
  assign bus_own   = bus_own_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed + randomized image loads for prog_loader,
// checked against an image-level model of the expected memory writes.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr;
  logic        bus_own;
  logic        cpu_reset;
  logic        busy;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mon_err = 0;
  int dur;

  logic [12:0] wa[$];
  logic [7:0]  wd[$];
  logic [7:0]  img[$];

  logic [12:0] pa;
  logic [7:0]  pd;
  logic        pw = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prog_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
    .bus_own(bus_own), .cpu_reset(cpu_reset), .busy(busy), .err(err)
  );

  // Write monitor: log each strobe, flag wide strobes or bus movement
  // in the cycle before or after a strobe.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_wr) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_data);
        if (pw || mem_addr !== pa || mem_data !== pd) mon_err++;
      end
      if (pw && (mem_wr || mem_addr !== pa || mem_data !== pd)) mon_err++;
    end
    pa = mem_addr;
    pd = mem_data;
    pw = mem_wr && reset;
  end
  always @(negedge reset) pw = 1'b0;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_data"}, mem_data, 0);
    chk({tag, "_bus_own"}, bus_own, 1);
    chk({tag, "_cpu_reset"}, cpu_reset, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Called at a negedge; returns at a negedge after the byte transferred.
  task automatic send(input logic [7:0] b, input int gap);
    bit got;
    int n;
    got = 0;
    n = 0;
    while (!got && n < 400) begin
      if ($urandom_range(99) < gap) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
      end
      got = in_valid && in_ready;
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!got) chk("send_timeout", 0, 1);
  endtask

  task automatic do_load(input logic [12:0] a, input int len,
                         input logic [7:0] cdelta, input logic [2:0] junk,
                         input int gap, input bit midstart);
    logic [7:0]  s;
    logic [7:0]  cs;
    logic [12:0] l;
    int t0;
    bit ok;
    s = 0;
    foreach (img[i]) s = s + img[i];
    cs = s + cdelta;
    ok = (cs == s);
    l = 13'(len);
    wa.delete();
    wd.delete();
    t0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send({junk, a[12:8]}, gap);
    send(a[7:0], gap);
    send({junk, l[12:8]}, gap);
    send(l[7:0], gap);
    for (int i = 0; i < len; i++) begin
      send(img[i], gap);
      if (midstart && i == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    send(cs, gap);
    dur = cyc - t0;
    if (gap == 0) chk("load_cycles", dur, 6 + 4 * len);
    chk("nwrites", wa.size(), len);
    for (int i = 0; i < len && i < wa.size(); i++) begin
      chk("wr_addr", wa[i], 32'((a + 13'(i)) & 13'h1FFF));
      chk("wr_data", wd[i], img[i]);
    end
    chk("busy_end", busy, 0);
    chk("in_ready_end", in_ready, 0);
    chk("mem_wr_end", mem_wr, 0);
    chk("cpu_reset_end", cpu_reset, ok);
    chk("bus_own_end", bus_own, !ok);
    chk("err_end", err, !ok);
    if (ok) begin
      chk("addr_done", mem_addr, 0);
      chk("data_done", mem_data, 0);
    end
    chk("bus_stable", mon_err, 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_chk("por");
    reset = 1'b1;
    @(negedge clk);
    rst_chk("idle");

    // Basic image
    img = '{8'h11, 8'h22, 8'h33};
    do_load(13'h0000, 3, 8'h00, 3'b000, 0, 0);

    // Bad checksum, then recovery
    do_load(13'h0000, 3, 8'h01, 3'b000, 0, 0);
    do_load(13'h0000, 3, 8'h00, 3'b101, 0, 0);

    // Address wrap, header bytes 0xFF,0xFE
    img = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_load(13'h1FFE, 4, 8'h00, 3'b111, 0, 0);

    // Empty image
    img.delete();
    do_load(13'h0123, 0, 8'h00, 3'b000, 0, 0);

    // Start mid-load is ignored
    img = '{8'h5A, 8'hA5, 8'h0F};
    do_load(13'h0400, 3, 8'h00, 3'b010, 0, 1);

    // Random images with stream gaps
    for (int k = 0; k < 8; k++) begin
      int len;
      logic [7:0] cd;
      len = $urandom_range(1, 12);
      img.delete();
      for (int i = 0; i < len; i++) img.push_back(8'($urandom));
      cd = (k % 3 == 2) ? 8'($urandom_range(1, 255)) : 8'h00;
      do_load(13'($urandom), len, cd, 3'($urandom),
              (k == 0) ? 0 : 30, 0);
    end

    // Reset during the second data byte's write strobe
    img = '{8'h01, 8'h02, 8'h03, 8'h04};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h04, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    @(negedge clk);
    chk("wr2_strobe", mem_wr, 1);
    chk("wr2_addr", mem_addr, 13'h0101);
    #3 reset = 1'b0;
    #1 rst_chk("midrst");
    @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    rst_chk("post_rst");

    img = '{8'h77, 8'h88};
    do_load(13'h0010, 2, 8'h00, 3'b000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
